// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, header size
// and the default acknowledge byte.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES        = 4;
  localparam logic [7:0]  DEFAULT_ACK_BYTE = 8'hAA;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte accumulator: each push lands at the next byte lane, and
// full_c flags the push that completes the word.
module byte_packer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [7:0]            din,
  output logic [NBYTES*8-1:0]   word_c,
  output logic                  full_c
);

  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NBYTES*8-1:0] word_q;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_d;

  // word_c already contains this cycle's byte so a consumer can use it at once
  always_comb begin
    word_c = word_q;
    cnt_d  = cnt;
    full_c = 1'b0;
    if (clr) begin
      word_c = '0;
      cnt_d  = '0;
    end else if (push) begin
      word_c[32'(cnt) * 32'd8 +: 8] = din;
      full_c = (cnt == CW'(NBYTES - 1));
      cnt_d  = full_c ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt    <= '0;
    end else begin
      word_q <= word_c;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a length-prefixed program over a byte stream, writes it word by word
// into instruction memory, then raises done and sends an acknowledge byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MAX_WORDS  = 4096,
  parameter logic [7:0]            ACK_BYTE   = DEFAULT_ACK_BYTE,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  tx_valid,
  output logic [7:0]            tx_data
);

  localparam int unsigned BPW   = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LEN_W = HDR_BYTES * 8;

  state_t state;
  state_t state_d;

  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      word_cnt_d;

  logic                  hdr_clr;
  logic                  hdr_push;
  logic                  hdr_full_c;
  logic [LEN_W-1:0]      hdr_word_c;

  logic                  dat_clr;
  logic                  dat_push;
  logic                  dat_full_c;
  logic [DATA_WIDTH-1:0] dat_word_c;

  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  err_d;
  logic                  tx_valid_d;
  logic [7:0]            tx_data_d;

  byte_packer #(.NBYTES(HDR_BYTES)) u_hdr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hdr_clr),
    .push   (hdr_push),
    .din    (rx_data),
    .word_c (hdr_word_c),
    .full_c (hdr_full_c)
  );

  byte_packer #(.NBYTES(BPW)) u_dat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (dat_clr),
    .push   (dat_push),
    .din    (rx_data),
    .word_c (dat_word_c),
    .full_c (dat_full_c)
  );

  // Next state; the header packer holds len untouched until the next start
  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    hdr_clr    = 1'b0;
    hdr_push   = 1'b0;
    dat_clr    = 1'b0;
    dat_push   = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR;
          hdr_clr    = 1'b1;
          dat_clr    = 1'b1;
          word_cnt_d = '0;
        end
      end
      HDR: begin
        if (rx_valid) begin
          hdr_push = 1'b1;
          if (hdr_full_c) begin
            if (hdr_word_c == '0)                    state_d = DONE;
            else if (hdr_word_c > LEN_W'(MAX_WORDS)) state_d = ERR;
            else                                     state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          dat_push = 1'b1;
          if (dat_full_c) state_d = WRITE;
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt + 32'd1;
        state_d    = (word_cnt_d == hdr_word_c) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is heading
  always_comb begin
    we_d       = (state_d == WRITE);
    addr_d     = addr;
    dout_d     = dout;
    busy_d     = (state_d == HDR) || (state_d == DATA) || (state_d == WRITE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    tx_valid_d = (state_d == DONE) && (state != DONE);
    tx_data_d  = tx_data;
    if (we_d) begin
      addr_d = BASE_ADDR + ADDR_WIDTH'(word_cnt * CNT_W'(BPW));
      dout_d = dat_word_c;
    end
    if (tx_valid_d) tx_data_d = ACK_BYTE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      we       <= 1'b0;
      addr     <= BASE_ADDR;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_d;
      word_cnt <= word_cnt_d;
      we       <= we_d;
      addr     <= addr_d;
      dout     <= dout_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: three instances (32-bit base 0, 64-bit
// base 0, 32-bit base 0x100), all limited to 16 words.
module tb_prog_loader;

  localparam int unsigned MAXW = 16;

  typedef struct {
    int          inst;
    bit          is_ack;
    bit          after_we;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       start;
  logic [2:0]       rx_valid;
  logic [2:0][7:0]  rx_data;
  wire  [2:0]       we, busy, done, err, tx_valid;
  wire  [2:0][31:0] addr;
  wire  [2:0][7:0]  tx_data;
  wire  [31:0]      dout0, dout2;
  wire  [63:0]      dout1;
  logic [63:0]      doutx [3];

  exp_t        exp_q[$];
  logic [63:0] wq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [2:0]  prev_rx = '0;
  logic [2:0]  prev_we = '0;

  always #5 clk = ~clk;

  prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WORDS(MAXW), .ACK_BYTE(8'hAA),
                .BASE_ADDR(32'h0)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .we(we[0]), .addr(addr[0]), .dout(dout0), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]));

  prog_loader #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_WORDS(MAXW), .ACK_BYTE(8'hAA),
                .BASE_ADDR(32'h0)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .we(we[1]), .addr(addr[1]), .dout(dout1), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]));

  prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WORDS(MAXW), .ACK_BYTE(8'hAA),
                .BASE_ADDR(32'h100)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .rx_valid(rx_valid[2]), .rx_data(rx_data[2]),
    .we(we[2]), .addr(addr[2]), .dout(dout2), .busy(busy[2]), .done(done[2]), .err(err[2]),
    .tx_valid(tx_valid[2]), .tx_data(tx_data[2]));

  assign doutx[0] = {32'h0, dout0};
  assign doutx[1] = dout1;
  assign doutx[2] = {32'h0, dout2};

  function automatic int unsigned bpw_of(input int i);
    return (i == 1) ? 8 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h100 : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse and every acknowledge must match the queue head
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i]) chk("rx_during_write", 64'(we[i]), 64'd0);
      if (we[i]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 64'(i), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("we_kind", 64'(e.is_ack), 64'd0);
          chk("we_inst", 64'(i), 64'(e.inst));
          chk("we_addr", 64'(addr[i]), 64'(e.addr));
          chk("we_data", doutx[i], e.data);
          chk("we_latency", 64'(prev_rx[i]), 64'd1);
        end
      end
      if (tx_valid[i]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tx", 64'(i), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_kind", 64'(e.is_ack), 64'd1);
          chk("tx_inst", 64'(i), 64'(e.inst));
          chk("tx_data", 64'(tx_data[i]), 64'hAA);
          chk("tx_with_done", 64'(done[i]), 64'd1);
          if (e.after_we) chk("done_after_write", 64'(prev_we[i]), 64'd1);
          else            chk("done_after_hdr", 64'(prev_rx[i]), 64'd1);
        end
      end
    end
    prev_rx = rx_valid;
    prev_we = we;
  end

  task automatic send_byte(input int i, input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid[i] = 1'b1;
    rx_data[i]  = b;
    @(posedge clk); #1;
    rx_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic noise(input int i, input int n);
    for (int k = 0; k < n; k++) send_byte(i, 8'($urandom));
    chk("noise_busy", 64'(busy[i]), 64'd0);
  endtask

  task automatic fill_random(input int i, input int n);
    logic [63:0] w;
    wq.delete();
    for (int k = 0; k < n; k++) begin
      w = {$urandom, $urandom};
      if (bpw_of(i) == 4) w[63:32] = 32'h0;
      wq.push_back(w);
    end
  endtask

  task automatic chk_reset(input int i);
    chk("rst_we", 64'(we[i]), 64'd0);
    chk("rst_addr", 64'(addr[i]), 64'(base_of(i)));
    chk("rst_dout", doutx[i], 64'd0);
    chk("rst_busy", 64'(busy[i]), 64'd0);
    chk("rst_done", 64'(done[i]), 64'd0);
    chk("rst_err", 64'(err[i]), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid[i]), 64'd0);
    chk("rst_tx_data", 64'(tx_data[i]), 64'd0);
  endtask

  // Full load: expectations come from the word list and the length rules only
  task automatic do_load(input int i, input logic [31:0] len);
    exp_t        e;
    bit          over;
    int unsigned bpw;
    bpw  = bpw_of(i);
    over = (len > 32'(MAXW));
    if (!over) begin
      for (int k = 0; k < int'(len); k++) begin
        e.inst = i; e.is_ack = 1'b0; e.after_we = 1'b0;
        e.addr = base_of(i) + 32'(k * int'(bpw));
        e.data = wq[k];
        exp_q.push_back(e);
      end
      e.inst = i; e.is_ack = 1'b1; e.after_we = (len != 0);
      e.addr = '0; e.data = '0;
      exp_q.push_back(e);
    end
    pulse_start(i);
    chk("start_busy", 64'(busy[i]), 64'd1);
    chk("start_done_clr", 64'(done[i]), 64'd0);
    chk("start_err_clr", 64'(err[i]), 64'd0);
    for (int b = 0; b < 4; b++) send_byte(i, len[8*b +: 8]);
    if (over) begin
      chk("over_err", 64'(err[i]), 64'd1);
      chk("over_busy", 64'(busy[i]), 64'd0);
      chk("over_done", 64'(done[i]), 64'd0);
    end else begin
      for (int k = 0; k < int'(len); k++)
        for (int b = 0; b < int'(bpw); b++) send_byte(i, wq[k][8*b +: 8]);
      chk("load_done", 64'(done[i]), 64'd1);
      chk("load_busy", 64'(busy[i]), 64'd0);
      chk("load_err", 64'(err[i]), 64'd0);
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] len;
    int          i;
    int          r;
    rst_n    = 1'b0;
    start    = '0;
    rx_valid = '0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    @(negedge clk);
    rst_n = 1'b1;

    noise(0, 3);

    // Nominal two-word program
    wq.delete();
    wq.push_back(64'h3e800093);
    wq.push_back(64'h83000113);
    do_load(0, 32'd2);

    do_load(0, 32'd0);

    fill_random(0, 0);
    do_load(0, 32'h11);
    fill_random(0, 1);
    do_load(0, 32'd1);

    fill_random(0, int'(MAXW));
    do_load(0, 32'(MAXW));
    noise(0, 2);

    // Reset after six data bytes: only the first word may be written
    fill_random(0, 3);
    e.inst = 0; e.is_ack = 1'b0; e.after_we = 1'b0; e.addr = 32'h0; e.data = wq[0];
    exp_q.push_back(e);
    pulse_start(0);
    for (int b = 0; b < 4; b++) send_byte(0, 8'(b == 0 ? 3 : 0));
    for (int b = 0; b < 6; b++) send_byte(0, wq[b / 4][8*(b % 4) +: 8]);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk("midload_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    noise(0, 4);
    fill_random(0, 2);
    do_load(0, 32'd2);

    // Non-zero base address, reloaded after noise
    fill_random(2, 3);
    do_load(2, 32'd3);
    noise(2, 3);
    fill_random(2, 2);
    do_load(2, 32'd2);

    // 64-bit word assembly
    wq.delete();
    wq.push_back(64'h0807060504030201);
    do_load(1, 32'd1);
    fill_random(1, 3);
    do_load(1, 32'd3);

    for (int n = 0; n < 14; n++) begin
      i = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r == 0)      len = 32'd0;
      else if (r == 1) len = 32'(MAXW + 1 + $urandom_range(0, 200));
      else if (r == 2) len = 32'hFFFF_FFF0;
      else             len = 32'($urandom_range(1, 4));
      fill_random(i, (len > 32'(MAXW)) ? 0 : int'(len));
      do_load(i, len);
      if (r > 7) noise(i, 2);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Successor to the fixed-program instruction generator.
- Instead of a hard-coded program, it receives a length-prefixed program as a byte stream from the UART receiver.
- It assembles little-endian words and writes them sequentially into instruction memory.
- It then signals `done` to release the core from reset-hold.
- Word width, memory depth, address stride and the acknowledge byte are parametrised.

Parameters:
- `DATA_WIDTH`, 32, instruction word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 32, width of the memory byte address.
- `MAX_WORDS`, 4096, capacity of instruction memory in words; larger headers are rejected.
- `ACK_BYTE`, 8'hAA, byte emitted on tx after a successful load.
- `BASE_ADDR`, 0, byte address of the first word written.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse that arms a new load
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `we`  out  1  instruction memory write enable
- `addr`  out  `ADDR_WIDTH`  memory byte address
- `dout`  out  `DATA_WIDTH`  memory write data
- `busy`  out  1  load in progress (HDR, DATA or WRITE state)
- `done`  out  1  load complete; sticky
- `err`  out  1  header exceeded `MAX_WORDS`; sticky
- `tx_valid`  out  1  one-cycle strobe for the UART transmitter
- `tx_data`  out  8  byte to transmit

Behaviour:
- Reset (async assert, sync release): state IDLE; `we`=0; `addr`=`BASE_ADDR`; `dout`=0; `busy`=`done`=`err`=0; `tx_valid`=0; `tx_data`=0; all counters 0.
- `BPW` = `DATA_WIDTH`/8, the bytes per word.
- Header is always 4 bytes, little-endian, and gives `len` = number of words.
- States:
  - IDLE: `start` → HDR; clears `done`, `err`, the byte counter and the word counter.
  - HDR: each `rx_valid` shifts the byte into `len` at position byte_cnt*8. On the 4th byte:
    - `len`==0 → DONE;
    - `len` > `MAX_WORDS` → ERR;
    - else → DATA.
  - DATA: each `rx_valid` places the byte into the word shift register at byte_cnt*8. On byte `BPW`-1 → WRITE.
  - WRITE (exactly 1 cycle): `we`=1, `addr`=`BASE_ADDR`+word_cnt*`BPW`, `dout`=assembled word. word_cnt increments. If word_cnt+1==`len` → DONE, else → DATA.
  - DONE: `done`=1, `busy`=0. On entry `tx_valid`=1 for one cycle with `tx_data`=`ACK_BYTE`. `start` → HDR (reload).
  - ERR: `err`=1, `busy`=0, no tx. `start` → HDR.
- Latency:
  - `we` is high in the cycle after the `rx_valid` of the word's last byte.
  - `done` rises the cycle after the final WRITE.
  - `tx_valid` coincides with the first `done` cycle.
- `rx_valid` during WRITE is illegal: the UART byte period exceeds 2 cycles, so it does not occur. The bench asserts this never happens.
- `rx_valid` in IDLE, DONE or ERR is ignored.
- `start` while `busy` is ignored.
- `we` is 0 in every state except WRITE.
- `addr` holds its last value outside WRITE.
- word_cnt is 32 bits internally. The address computation truncates to `ADDR_WIDTH`.
- Reset mid-load returns the block to IDLE immediately. Memory contents already written are left unchanged.

Decomposition:
- Shared package `loader_pkg`:
  - state enum `{IDLE, HDR, DATA, WRITE, DONE, ERR}`;
  - `HDR_BYTES`=4;
  - default `ACK_BYTE` constant.
- One sub-module: `byte_packer`, parametrised by `NBYTES`. It accumulates little-endian bytes, exposes a `full` flag, and clears on demand.
- Both the header and the data paths instantiate `byte_packer`.

Test Plan:
- Nominal load: `start`, then bytes 02 00 00 00 | 93 00 80 3e | 13 01 00 83 →
  - `we` pulse with `addr`=0, `dout`=32'h3e800093;
  - `we` pulse with `addr`=4, `dout`=32'h83000113;
  - then `done`=1, one `tx_valid` with `tx_data`=8'hAA;
  - exactly 2 `we` pulses in total.
- Zero length: `start`, 00 00 00 00 → no `we`; `done`=1 the cycle after the 4th byte; `tx_data`=AA.
- Oversize: `MAX_WORDS`=16, header 11 00 00 00 → `err`=1, `busy`=0, no `we`, no `tx_valid`. A following `start` with header 01 00 00 00 and one word loads normally.
- Reset mid-load: `rst_n` low after 6 data bytes → outputs at reset values within the same cycle; no further `we`; stray `rx_valid` is ignored until `start`.
- Noise and re-arm: `rx_valid` bytes before `start` and after `done` → ignored. A second `start` reloads from `BASE_ADDR`=0x100 (param override), first write to `addr`=0x100.
- Width variant: `DATA_WIDTH`=64, header 01 00 00 00, bytes 01..08 → single `we`, `addr`=0, `dout`=64'h0807060504030201.
